// File: rtl/instruction_controller.sv
// Control FSM for a small register-file processor: fetches a 9-bit instruction on run
// and sequences register, ALU and done enables over T1..T3.
module instruction_controller #(
    parameter int n = 8
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       run,
    input  logic [8:0] ir_in,
    input  logic       z_flag,
    output logic       ir_load,
    output logic       din_out,
    output logic       a_in,
    output logic       g_in,
    output logic       g_out,
    output logic       done,
    output logic [7:0] r_in,
    output logic [7:0] r_out,
    output logic [1:0] alu_op,
    output logic       add_sub_control,
    output logic       cin
);
    typedef enum logic [1:0] {T0, T1, T2, T3} state_t;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_MVNZ = 3'b101;

    // n only documents the attached ALU width; it is always positive so this is 1.
    localparam logic ZREG_RST = (n > 0);

    state_t     state;
    logic [8:0] ir;
    logic       zreg;
    logic [2:0] op;
    logic [7:0] x_oh, y_oh;
    logic       alu_instr;

    assign op        = ir[8:6];
    assign x_oh      = 8'b1 << ir[5:3];
    assign y_oh      = 8'b1 << ir[2:0];
    assign alu_instr = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= T0;
            ir    <= '0;
            zreg  <= ZREG_RST;
        end else begin
            case (state)
                T0: if (run) begin
                    ir    <= ir_in;
                    state <= T1;
                end
                T1: state <= alu_instr ? T2 : T0;
                T2: begin
                    zreg  <= z_flag;
                    state <= T3;
                end
                default: state <= T0;
            endcase
        end
    end

    always_comb begin
        ir_load         = 1'b0;
        din_out         = 1'b0;
        a_in            = 1'b0;
        g_in            = 1'b0;
        g_out           = 1'b0;
        done            = 1'b0;
        r_in            = '0;
        r_out           = '0;
        alu_op          = 2'b00;
        add_sub_control = 1'b0;
        cin             = 1'b0;
        case (state)
            // resetn gating keeps ir_load low while reset holds state at T0
            T0: ir_load = run & resetn;
            T1: begin
                case (op)
                    OP_MV: begin
                        r_out = y_oh;
                        r_in  = x_oh;
                        done  = 1'b1;
                    end
                    OP_MVI: begin
                        din_out = 1'b1;
                        r_in    = x_oh;
                        done    = 1'b1;
                    end
                    OP_ADD, OP_SUB, OP_AND: begin
                        r_out = x_oh;
                        a_in  = 1'b1;
                    end
                    OP_MVNZ: begin
                        done = 1'b1;
                        if (!zreg) begin
                            r_out = y_oh;
                            r_in  = x_oh;
                        end
                    end
                    default: done = 1'b1;
                endcase
            end
            T2: begin
                r_out = y_oh;
                g_in  = 1'b1;
                if (op == OP_SUB) begin
                    add_sub_control = 1'b1;
                    cin             = 1'b1;
                end
                if (op == OP_AND) alu_op = 2'b01;
            end
            default: begin
                g_out = 1'b1;
                r_in  = x_oh;
                done  = 1'b1;
            end
        endcase
    end
endmodule

// File: tb/tb_instruction_controller.sv
// Randomized bench for instruction_controller: a per-instruction output schedule model
// checked every cycle, plus directed literal checks of the main sequences.
module tb_instruction_controller;
    typedef struct packed {
        logic       ir_load, din_out, a_in, g_in, g_out, done;
        logic [7:0] r_in, r_out;
        logic [1:0] alu_op;
        logic       add_sub_control, cin;
    } outs_t;
    typedef struct packed {
        outs_t o;
        logic  capz;
    } ent_t;

    logic       clk = 0;
    logic       resetn = 0;
    logic       run = 1;
    logic [8:0] ir_in = 9'h1ff;
    logic       z_flag = 0;
    logic       ir_load, din_out, a_in, g_in, g_out, done;
    logic [7:0] r_in, r_out;
    logic [1:0] alu_op;
    logic       add_sub_control, cin;
    outs_t      dut_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_done = -1;
    int done_gap = 0;

    ent_t q[$];
    logic zreg_m = 1'b1;

    localparam logic [8:0] MVI_R3    = 9'b001_011_000;
    localparam logic [8:0] SUB_R1R2  = 9'b011_001_010;
    localparam logic [8:0] AND_R0R0  = 9'b100_000_000;
    localparam logic [8:0] MVNZ_R0R5 = 9'b101_000_101;
    localparam logic [8:0] ADD_R3R4  = 9'b010_011_100;

    instruction_controller #(.n(8)) dut (
        .clk(clk), .resetn(resetn), .run(run), .ir_in(ir_in), .z_flag(z_flag),
        .ir_load(ir_load), .din_out(din_out), .a_in(a_in), .g_in(g_in), .g_out(g_out),
        .done(done), .r_in(r_in), .r_out(r_out), .alu_op(alu_op),
        .add_sub_control(add_sub_control), .cin(cin)
    );

    assign dut_o = {ir_load, din_out, a_in, g_in, g_out, done, r_in, r_out,
                    alu_op, add_sub_control, cin};

    always #5 clk = ~clk;

    function automatic logic [7:0] oh(input logic [2:0] k);
        logic [7:0] v;
        v = 8'b1;
        return v << k;
    endfunction

    // Expand one fetched instruction into the outputs of each of its execute cycles.
    function automatic void schedule(input logic [8:0] w);
        ent_t e;
        logic [2:0] op, x, y;
        op = w[8:6]; x = w[5:3]; y = w[2:0];
        e = '0;
        if (op == 3'd2 || op == 3'd3 || op == 3'd4) begin
            e.o.r_out = oh(x); e.o.a_in = 1'b1;
            q.push_back(e);
            e = '0;
            e.o.r_out = oh(y); e.o.g_in = 1'b1; e.capz = 1'b1;
            e.o.alu_op = (op == 3'd4) ? 2'b01 : 2'b00;
            e.o.add_sub_control = (op == 3'd3);
            e.o.cin = (op == 3'd3);
            q.push_back(e);
            e = '0;
            e.o.g_out = 1'b1; e.o.r_in = oh(x); e.o.done = 1'b1;
            q.push_back(e);
        end else begin
            e.o.done = 1'b1;
            if (op == 3'd0 || (op == 3'd5 && !zreg_m)) begin
                e.o.r_out = oh(y); e.o.r_in = oh(x);
            end
            if (op == 3'd1) begin
                e.o.din_out = 1'b1; e.o.r_in = oh(x);
            end
            q.push_back(e);
        end
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q.delete();
            zreg_m = 1'b1;
        end else if (q.size() > 0) begin
            if (q[0].capz) zreg_m = z_flag;
            void'(q.pop_front());
        end else if (run) begin
            schedule(ir_in);
        end
    end

    always @(negedge clk) begin
        outs_t e;
        e = '0;
        if (resetn) begin
            if (q.size() > 0) e = q[0].o;
            else e.ir_load = run;
        end
        checks++;
        if (dut_o !== e) begin
            errors++;
            $display("FAIL model cycle %0d: outputs got %h expected %h", cyc, dut_o, e);
        end
        if (done === 1'b1) begin
            if (last_done >= 0) done_gap = cyc - last_done;
            last_done = cyc;
        end
        cyc++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic rn, input logic r, input logic [8:0] w, input logic z);
        @(posedge clk);
        #1;
        resetn = rn; run = r; ir_in = w; z_flag = z;
        @(negedge clk);
        #1;
    endtask

    initial begin
        step(0, 1, 9'h1ff, 0);
        step(0, 1, 9'h1ff, 0);
        chk("reset_outputs_zero", 32'(dut_o), 0);

        step(1, 1, MVI_R3, 0);
        chk("first_t0_ir_load", 32'(ir_load), 1);
        step(1, 0, 0, 0);
        chk("mvi_din_out", 32'(din_out), 1);
        chk("mvi_r_in", 32'(r_in), 32'h08);
        chk("mvi_done", 32'(done), 1);
        step(1, 0, 0, 0);
        chk("after_mvi_idle", 32'(dut_o), 0);

        step(1, 1, SUB_R1R2, 0);
        chk("sub_ir_load", 32'(ir_load), 1);
        step(1, 0, 0, 0);
        chk("sub_t1_r_out", 32'(r_out), 32'h02);
        chk("sub_t1_a_in", 32'(a_in), 1);
        step(1, 0, 0, 0);
        chk("sub_t2_r_out", 32'(r_out), 32'h04);
        chk("sub_t2_ctrl", 32'({g_in, add_sub_control, cin, alu_op}), 32'b11100);
        step(1, 0, 0, 0);
        chk("sub_t3", 32'({g_out, done, r_in}), 32'h302);

        for (int rep = 0; rep < 2; rep++) begin
            step(1, 1, AND_R0R0, 0);
            step(1, 0, 0, 0);
            step(1, 0, 0, (rep == 0));
            chk("and_t2_alu_op", 32'(alu_op), 32'b01);
            step(1, 0, 0, 0);
            step(1, 1, MVNZ_R0R5, 0);
            step(1, 0, 0, 0);
            chk("mvnz_done", 32'(done), 1);
            chk("mvnz_r_out", 32'(r_out), (rep == 0) ? 32'h00 : 32'h20);
            chk("mvnz_r_in", 32'(r_in), (rep == 0) ? 32'h00 : 32'h01);
        end

        step(1, 1, ADD_R3R4, 0);
        chk("add1_ir_load", 32'(ir_load), 1);
        step(1, 1, ADD_R3R4, 0);
        step(1, 1, ADD_R3R4, 0);
        step(1, 1, ADD_R3R4, 0);
        chk("add1_done", 32'(done), 1);
        step(1, 1, ADD_R3R4, 0);
        chk("add2_ir_load", 32'(ir_load), 1);
        step(1, 1, ADD_R3R4, 0);
        step(1, 1, ADD_R3R4, 0);
        step(1, 0, ADD_R3R4, 0);
        chk("add2_done", 32'(done), 1);
        chk("done_gap", 32'(done_gap), 4);

        step(1, 1, ADD_R3R4, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("abort_t2_g_in", 32'(g_in), 1);
        #1 resetn = 0;
        #1 chk("abort_outputs_zero", 32'(dut_o), 0);
        step(0, 0, 0, 0);
        step(1, 1, MVNZ_R0R5, 0);
        chk("post_abort_ir_load", 32'(ir_load), 1);
        step(1, 0, 0, 0);
        chk("post_abort_mvnz", 32'({done, r_in, r_out}), 32'h10000);

        for (int i = 0; i < 600; i++)
            step(($urandom_range(99) != 0), ($urandom_range(9) < 7),
                 9'($urandom), 1'($urandom));
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
